// File: rtl/sdram_timing_pkg.sv
// sdram_timing_pkg
// Shared constants for the SDRAM timing timer bank:
//   - channel index assignments used by the SDRAM command FSM
//   - default interval lengths in clock cycles
//   - channel mode encoding (one-shot / auto-reload)
package sdram_timing_pkg;

  // Channel index assignments
  localparam int CH_RCD = 0;
  localparam int CH_RP  = 1;
  localparam int CH_WR  = 2;
  localparam int CH_REF = 3;

  // Default intervals in cycles. T_REFI is board/clock specific and is
  // sized here to fit the default 4-bit counter.
  localparam int T_RCD  = 2;
  localparam int T_RP   = 2;
  localparam int T_WR   = 2;
  localparam int T_RFC  = 7;
  localparam int T_REFI = 15;

  // Channel mode, sampled together with start
  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/sdram_timing_timer_if.sv
// sdram_timing_timer_if
// Bundles the timer bank's control and status signals.
//   master : command FSM side (drives start/load_val/periodic/cancel,
//            observes busy/expire/all_idle)
//   slave  : timer bank side
interface sdram_timing_timer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
);
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH*CNT_W-1:0] load_val;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH-1:0]       cancel;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       expire;
  logic                    all_idle;

  modport master (
    output start, load_val, periodic, cancel,
    input  busy, expire, all_idle
  );

  modport slave (
    input  start, load_val, periodic, cancel,
    output busy, expire, all_idle
  );
endinterface

// File: rtl/sdram_timer_channel.sv
// sdram_timer_channel
// One down-counting timing channel. A start loads the interval (0 treated
// as 1); when the count reaches 1 the channel emits a one-cycle expire and
// either goes idle (one-shot) or reloads (periodic). Cancel aborts and
// suppresses any pending expire; cancel beats start.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load load_val and begin counting
//   load_val   : interval length in cycles
//   periodic   : mode sampled with start
//   cancel     : abort the channel
//   busy       : registered, channel counting
//   expire     : registered one-cycle completion pulse
//   busy_nxt   : next-state busy, used by the parent for all_idle
module sdram_timer_channel
  import sdram_timing_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  input  logic             periodic,
  input  logic             cancel,
  output logic             busy,
  output logic             expire,
  output logic             busy_nxt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  mode_e            mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             expire_q, expire_d;
  logic [CNT_W-1:0] eff_load;

  always_comb begin
    eff_load = (load_val == '0) ? ONE : load_val;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    expire_d = 1'b0;

    if (cancel) begin
      if (busy_q) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else begin
      // The completing interval still reports even if a restart lands on
      // the same cycle.
      expire_d = busy_q && (cnt_q == ONE);
      if (start) begin
        cnt_d    = eff_load;
        reload_d = eff_load;
        mode_d   = mode_e'(periodic);
        busy_d   = 1'b1;
      end else if (busy_q) begin
        if (cnt_q == ONE) begin
          if (mode_q == MODE_PERIODIC) begin
            cnt_d = reload_q;
          end else begin
            busy_d = 1'b0;
            cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      busy_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      expire_q <= expire_d;
    end
  end

  assign busy     = busy_q;
  assign expire   = expire_q;
  // Reset forces idle, so the parent sees the same value it registers.
  assign busy_nxt = busy_d;

endmodule

// File: rtl/sdram_timing_timer.sv
// sdram_timing_timer
// Bank of NUM_CH independent SDRAM timing channels plus a registered
// all-idle flag.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of sdram_timing_timer_if
//           (start, load_val, periodic, cancel in; busy, expire, all_idle out)
module sdram_timing_timer
  import sdram_timing_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_timing_timer_if.slave  bus
);

  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] expire_w;
  logic [NUM_CH-1:0] busy_nxt_w;
  logic              all_idle_q, all_idle_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sdram_timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .start    (bus.start[g]),
      .load_val (bus.load_val[g*CNT_W +: CNT_W]),
      .periodic (bus.periodic[g]),
      .cancel   (bus.cancel[g]),
      .busy     (busy_w[g]),
      .expire   (expire_w[g]),
      .busy_nxt (busy_nxt_w[g])
    );
  end

  // Built from next-state busy so it lines up with the registered busy.
  always_comb begin
    all_idle_d = ~|busy_nxt_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      all_idle_q <= 1'b1;
    end else begin
      all_idle_q <= all_idle_d;
    end
  end

  assign bus.busy     = busy_w;
  assign bus.expire   = expire_w;
  assign bus.all_idle = all_idle_q;

endmodule

// File: tb/tb_sdram_timing_timer.sv
module tb_sdram_timing_timer;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sdram_timing_timer_if #(.NUM_CH(4), .CNT_W(4)) bus ();
  sdram_timing_timer_if #(.NUM_CH(1), .CNT_W(8)) bus2 ();

  sdram_timing_timer #(.NUM_CH(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sdram_timing_timer #(.NUM_CH(1), .CNT_W(8)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_exp;
    logic [3:0] exp_busy;
    int n;

    bus.start    = '0;
    bus.load_val = '0;
    bus.periodic = '0;
    bus.cancel   = '0;
    bus2.start    = '0;
    bus2.load_val = '0;
    bus2.periodic = '0;
    bus2.cancel   = '0;

    // Reset with start asserted
    reset = 1'b1;
    bus.start    = 4'hF;
    bus.load_val = 16'h3333;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_expire", 32'(bus.expire), 32'h0);
    chk("rst_all_idle", 32'(bus.all_idle), 32'h1);
    reset = 1'b0;
    bus.start = '0;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'h0);
    chk("idle_all_idle", 32'(bus.all_idle), 32'h1);

    // One-shot tRCD on channel 0, load 2
    bus.load_val[3:0] = 4'd2;
    bus.start = 4'b0001;
    tick();
    bus.start = '0;
    chk("rcd_busy_k", 32'(bus.busy), 32'h1);
    chk("rcd_exp_k", 32'(bus.expire), 32'h0);
    chk("rcd_idle_k", 32'(bus.all_idle), 32'h0);
    tick();
    chk("rcd_exp_k1", 32'(bus.expire), 32'h0);
    chk("rcd_busy_k1", 32'(bus.busy), 32'h1);
    tick();
    chk("rcd_exp_k2", 32'(bus.expire), 32'h1);
    chk("rcd_busy_k2", 32'(bus.busy), 32'h0);
    chk("rcd_idle_k2", 32'(bus.all_idle), 32'h1);
    tick();
    chk("rcd_exp_k3", 32'(bus.expire), 32'h0);

    // Periodic refresh on channel 3, R=5, cancel at edge 17
    bus.load_val[15:12] = 4'd5;
    bus.periodic = 4'b1000;
    bus.start    = 4'b1000;
    tick();
    bus.start    = '0;
    bus.periodic = '0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 17) bus.cancel = 4'b1000;
      tick();
      bus.cancel = '0;
      chk($sformatf("ref_exp_e%0d", e), 32'(bus.expire[3]), 32'((e % 5 == 0) && (e < 17)));
      chk($sformatf("ref_busy_e%0d", e), 32'(bus.busy[3]), 32'(e < 17));
    end

    // Zero load on channel 1 -> treated as 1
    bus.load_val[7:4] = 4'd0;
    bus.start = 4'b0010;
    tick();
    bus.start = '0;
    chk("zero_busy", 32'(bus.busy), 32'h2);
    tick();
    chk("zero_exp", 32'(bus.expire), 32'h2);
    chk("zero_busy_after", 32'(bus.busy), 32'h0);

    // Restart channel 2: load 4 at edge k, restart with 3 at edge k+2
    bus.load_val[11:8] = 4'd4;
    bus.start = 4'b0100;
    tick();
    bus.start = '0;
    tick();
    bus.load_val[11:8] = 4'd3;
    bus.start = 4'b0100;
    tick();
    bus.start = '0;
    chk("rst_k2_exp", 32'(bus.expire), 32'h0);
    tick();
    chk("rst_k3_exp", 32'(bus.expire), 32'h0);
    tick();
    chk("rst_k4_exp", 32'(bus.expire), 32'h0);
    tick();
    chk("rst_k5_exp", 32'(bus.expire), 32'h4);
    chk("rst_k5_busy", 32'(bus.busy), 32'h0);

    // Start coinciding with cnt==1 on channel 0
    bus.load_val[3:0] = 4'd2;
    bus.start = 4'b0001;
    tick();
    bus.start = '0;
    tick();
    bus.load_val[3:0] = 4'd3;
    bus.start = 4'b0001;
    tick();
    bus.start = '0;
    chk("coll_exp_k2", 32'(bus.expire), 32'h1);
    chk("coll_busy_k2", 32'(bus.busy), 32'h1);
    tick();
    chk("coll_exp_k3", 32'(bus.expire), 32'h0);
    tick();
    chk("coll_exp_k4", 32'(bus.expire), 32'h0);
    chk("coll_busy_k4", 32'(bus.busy), 32'h1);
    tick();
    chk("coll_exp_k5", 32'(bus.expire), 32'h1);
    chk("coll_busy_k5", 32'(bus.busy), 32'h0);

    // Cancel together with start on idle channel 1
    bus.load_val[7:4] = 4'd2;
    bus.start  = 4'b0010;
    bus.cancel = 4'b0010;
    tick();
    bus.start  = '0;
    bus.cancel = '0;
    chk("cs_busy", 32'(bus.busy), 32'h0);
    tick();
    tick();
    chk("cs_exp", 32'(bus.expire), 32'h0);
    chk("cs_idle", 32'(bus.all_idle), 32'h1);

    // Cancel with cnt==1 on channel 1
    bus.start = 4'b0010;
    tick();
    bus.start = '0;
    tick();
    bus.cancel = 4'b0010;
    tick();
    bus.cancel = '0;
    chk("c1_exp", 32'(bus.expire), 32'h0);
    chk("c1_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("c1_exp_after", 32'(bus.expire), 32'h0);

    // Parallel channels: loads 1, 2, 3, 15
    bus.load_val = {4'd15, 4'd3, 4'd2, 4'd1};
    bus.start = 4'hF;
    tick();
    bus.start = '0;
    chk("par_busy_k", 32'(bus.busy), 32'hF);
    for (int e = 1; e <= 16; e++) begin
      tick();
      exp_exp  = {e == 15, e == 3, e == 2, e == 1};
      exp_busy = {e < 15, e < 3, e < 2, e < 1};
      chk($sformatf("par_exp_e%0d", e), 32'(bus.expire), 32'(exp_exp));
      chk($sformatf("par_busy_e%0d", e), 32'(bus.busy), 32'(exp_busy));
      chk($sformatf("par_idle_e%0d", e), 32'(bus.all_idle), 32'(e >= 15));
    end

    // Periodic R=1 on channel 0: expire every cycle
    bus.load_val[3:0] = 4'd1;
    bus.periodic = 4'b0001;
    bus.start    = 4'b0001;
    tick();
    bus.start    = '0;
    bus.periodic = '0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("r1_exp_e%0d", e), 32'(bus.expire), 32'h1);
    end
    bus.cancel = 4'b0001;
    tick();
    bus.cancel = '0;
    chk("r1_cancel_exp", 32'(bus.expire), 32'h0);
    chk("r1_cancel_idle", 32'(bus.all_idle), 32'h1);

    // Reset mid-count on channel 3
    bus.load_val[15:12] = 4'd5;
    bus.start = 4'b1000;
    tick();
    bus.start = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_busy", 32'(bus.busy), 32'h0);
    chk("rmid_idle", 32'(bus.all_idle), 32'h1);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("rmid_exp_e%0d", e), 32'(bus.expire), 32'h0);
    end

    // 8-bit single-channel instance: load 255
    bus2.load_val = 8'd255;
    bus2.start    = 1'b1;
    tick();
    bus2.start    = 1'b0;
    chk("w8_busy", 32'(bus2.busy), 32'h1);
    chk("w8_idle", 32'(bus2.all_idle), 32'h0);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus2.expire[0]) begin
        n = i;
        break;
      end
    end
    chk("w8_latency", 32'(n), 32'd255);
    chk("w8_busy_end", 32'(bus2.busy), 32'h0);
    tick();
    chk("w8_exp_once", 32'(bus2.expire), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_timing_timer.md
Name: sdram_timing_timer

Overview:
Parametrised multi-channel down-counter bank that enforces SDRAM timing intervals such as tRCD, tRP, tRFC, tWR and the refresh interval. Each channel counts a load value supplied at start, then emits a one-cycle expire pulse. Channels run in one-shot or auto-reload mode. The block sits beside the SDRAM command FSM, which starts channels on command issue and waits on busy/expire.

Parameters:
NUM_CH, 4, number of independent timer channels (1..16)
CNT_W, 4, counter width per channel; maximum interval 2^CNT_W-1 cycles

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  NUM_CH  per-channel start strobe; samples that channel's load_val
load_val  input  NUM_CH*CNT_W  per-channel interval in cycles; channel i uses bits [i*CNT_W +: CNT_W]
periodic  input  NUM_CH  per-channel mode, sampled with start: 0 = one-shot, 1 = auto-reload
cancel  input  NUM_CH  per-channel abort
busy  output  NUM_CH  channel is counting
expire  output  NUM_CH  one-cycle pulse when the interval completes
all_idle  output  1  registered AND of ~busy across all channels

Behaviour:
- Reset: synchronous and active-high. On reset, count, reload, mode, busy and expire clear to 0, and all_idle sets to 1. Reset overrides start and cancel in the same cycle.
- Per-channel state: cnt[CNT_W], reload[CNT_W], mode bit, busy, expire. All outputs are registered.
- Start (start[i]=1, cancel[i]=0):
  - cnt <= eff, where eff = (load_val==0) ? 1 : load_val.
  - reload <= eff, mode <= periodic[i], busy <= 1.
- Counting (busy=1, no start, no cancel): if cnt > 1 then cnt <= cnt-1.
- Terminal (busy=1, cnt==1):
  - expire <= 1.
  - One-shot: busy <= 0.
  - Periodic: cnt <= reload and busy stays 1.
- Latency: start sampled at edge k gives expire high for exactly the cycle after edge k+eff. busy rises after edge k. In one-shot mode busy falls after edge k+eff, together with the expire rise.
- expire is high for a single cycle only. Otherwise expire <= 0.
- Restart while busy: start reloads cnt with the new value and the old interval is discarded. Exception: if cnt==1 in the same cycle, expire still pulses for the completing interval and the new interval begins. Mode is re-sampled on restart.
- Cancel: busy <= 0, cnt <= 0, expire <= 0, including when cnt==1 (a cancel suppresses the pending expire). Cancel has priority over start. Cancel on an idle channel has no effect.
- Periodic wrap: with reload R, expire pulses every R cycles indefinitely until cancel or reset. R=1 gives expire high on every cycle.
- Arithmetic is unsigned with no underflow: cnt never decrements below 1 while busy. A load_val of 0 is treated as 1.
- Channels are fully independent. Simultaneous events on different channels have no interaction.
- all_idle is registered from next-state busy, so it is coincident with busy.
- Reset mid-count: the channel goes idle with no expire pulse.

Decomposition:
- Shared package sdram_timing_pkg holds:
  - channel index constants: CH_RCD=0, CH_RP=1, CH_WR=2, CH_REF=3;
  - default interval constants: T_RCD=2, T_RP=2, T_WR=2, T_RFC=7, T_REFI (project-specific);
  - the mode encoding MODE_ONESHOT=0, MODE_PERIODIC=1.
- One sub-module, sdram_timer_channel, holds a single channel's counter, reload, mode, busy and expire with the same priority rules. The top level generates NUM_CH instances, slices load_val, and reduces busy into all_idle.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with start asserted -> busy=0, expire=0, all_idle=1; no activity after release.
- One-shot tRCD: start[0] with load_val=2 at edge 10 -> busy[0]=1 after edge 10; expire[0]=1 only after edge 12; busy[0]=0 after edge 12; all_idle=1 after edge 12.
- Periodic refresh: start[3] with load_val=5 and periodic=1 at edge 0 -> expire[3] pulses after edges 5, 10, 15; cancel at edge 17 -> busy[3]=0 after edge 17; no pulse at edge 20.
- Zero load and restart: load_val=0 -> expire after 1 cycle. Start with 4, then restart with 3 at edge k+2 -> expire after edge k+5, not after k+4.
- Collision cases:
  - start coinciding with cnt==1 -> expire pulses and the new interval runs in full;
  - cancel and start together -> channel idle, no expire;
  - cancel with cnt==1 -> no expire.
- Parallel channels: NUM_CH=4, all started with loads 1, 2, 3, 15 at the same edge -> each expires after its own count; all_idle=1 only after the 15th cycle. Also rerun with NUM_CH=1 and CNT_W=8 to cover a load of 255.
